// File: rtl/debounce_bank.sv
// debounce_bank: a bank of independent push-button debouncers.
// Each channel synchronises its raw input through two flops, integrates it in
// a saturating up/down counter, and flips its debounced level only when the
// counter reaches a bound (hysteresis). Press, release and long-press events
// are reported as single-cycle registered pulses.
module debounce_bank #(
    parameter int                  CHANNELS    = 4,
    parameter int                  THRESHOLD   = 100000,
    parameter int                  LONG_CYCLES = 50000000,
    parameter logic [CHANNELS-1:0] ACTIVE_LOW  = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] button,
    output logic [CHANNELS-1:0] button_db,
    output logic [CHANNELS-1:0] press_pulse,
    output logic [CHANNELS-1:0] release_pulse,
    output logic [CHANNELS-1:0] long_pulse
);

    localparam int              CW    = $clog2(THRESHOLD + 1);
    localparam logic [CW-1:0]   TOP_C = CW'(THRESHOLD);

    // Two-flop synchroniser; inversion happens first so "1" always means pressed.
    logic [CHANNELS-1:0] ff1;
    logic [CHANNELS-1:0] ff2;

    // Synchronise the polarity-corrected raw inputs into the clock domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            ff1 <= '0;
            ff2 <= '0;
        end else begin
            ff1 <= button ^ ACTIVE_LOW;
            ff2 <= ff1;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [CW-1:0] count;
        logic          at_top;
        logic          at_bottom;
        logic          db_q;
        logic          press_q;
        logic          release_q;

        assign at_top    = (count == TOP_C);
        assign at_bottom = (count == '0);

        // Saturating integrator: walk toward the synchronised level, never wrap.
        always_ff @(posedge clk) begin
            if (reset) begin
                count <= '0;
            end else if (ff2[i]) begin
                if (!at_top) count <= count + 1'b1;
            end else begin
                if (!at_bottom) count <= count - 1'b1;
            end
        end

        // Debounced level with hysteresis; edge pulses coincide with the level change.
        always_ff @(posedge clk) begin
            if (reset) begin
                db_q      <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                press_q   <= at_top & ~db_q;
                release_q <= at_bottom & db_q;
                if (at_top)         db_q <= 1'b1;
                else if (at_bottom) db_q <= 1'b0;
            end
        end

        assign button_db[i]     = db_q;
        assign press_pulse[i]   = press_q;
        assign release_pulse[i] = release_q;

        if (LONG_CYCLES > 0) begin : g_long
            localparam int            HW      = $clog2(LONG_CYCLES + 1);
            localparam logic [HW-1:0] LONG_C  = HW'(LONG_CYCLES);
            localparam logic [HW-1:0] LONG_M1 = HW'(LONG_CYCLES - 1);

            logic [HW-1:0] hold;
            logic          long_q;

            // Hold timer: runs while pressed, saturates so the pulse fires once per press.
            always_ff @(posedge clk) begin
                if (reset || !db_q) begin
                    hold   <= '0;
                    long_q <= 1'b0;
                end else begin
                    if (hold != LONG_C) hold <= hold + 1'b1;
                    long_q <= (hold == LONG_M1);
                end
            end

            assign long_pulse[i] = long_q;
        end else begin : g_no_long
            assign long_pulse[i] = 1'b0;
        end
    end

endmodule

// File: doc/debounce_bank.md
DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 The block SHALL expose these parameters:
- CHANNELS, default 4: number of independent button channels (1..32).
- THRESHOLD, default 100000: counter level at which a channel is declared stable (>= 1).
- LONG_CYCLES, default 50000000: cycles of continuous debounced-pressed before a long-press pulse; 0 disables long-press.
- ACTIVE_LOW, default 0: CHANNELS-bit mask; bit i = 1 inverts raw input i so that debounced 1 always means "pressed".
REQ-002 The block SHALL have these ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- button  in  CHANNELS  raw asynchronous button inputs.
- button_db  out  CHANNELS  debounced level, 1 = pressed.
- press_pulse  out  CHANNELS  1-cycle pulse on debounced press.
- release_pulse  out  CHANNELS  1-cycle pulse on debounced release.
- long_pulse  out  CHANNELS  1-cycle pulse on long-press.
REQ-003 All outputs SHALL be registered on rising clk; there SHALL be no combinational input-to-output path.

Function
REQ-004 Each channel SHALL XOR its raw input with ACTIVE_LOW[i], then pass it through two flip-flops (ff1, ff2) before any other use.
REQ-005 Each channel SHALL have a saturating integrator counter of width $clog2(THRESHOLD+1), range 0..THRESHOLD inclusive.
REQ-006 If ff2 = 1 and count < THRESHOLD, count SHALL increment by 1; at THRESHOLD it SHALL hold (no wrap).
REQ-007 If ff2 = 0 and count > 0, count SHALL decrement by 1; at 0 it SHALL hold (no wrap).
REQ-008 Hysteresis rules for button_db[i]:
- SHALL set to 1 on the edge after count == THRESHOLD is observed.
- SHALL clear to 0 on the edge after count == 0 is observed.
- SHALL otherwise hold.
REQ-009 Latency: with a clean input step, and counting the edge that first samples the new level into ff1 as edge 1, button_db SHALL change on edge THRESHOLD+3.
REQ-010 press_pulse[i] SHALL be 1 for exactly the one cycle in which button_db[i] has just changed 0->1; release_pulse[i] likewise for 1->0.
REQ-011 Each channel SHALL have a hold counter that behaves as follows:
- cleared while button_db[i] = 0;
- incremented each cycle while button_db[i] = 1, saturating at LONG_CYCLES.
REQ-012 long_pulse[i] SHALL be 1 for one cycle when the hold counter transitions to LONG_CYCLES, and at most once per press; a release followed by a new press re-arms it.
REQ-013 With LONG_CYCLES = 0, long_pulse SHALL be constant 0 and the hold counter logic MAY be omitted.
REQ-014 Channels SHALL be fully independent; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.
REQ-015 An input glitch shorter than the remaining distance to the opposite bound SHALL NOT change button_db (the integrator only moves the count).

Reset
REQ-016 When reset = 1 at a rising edge, the block SHALL clear all of the following to 0, regardless of state or ongoing counting:
- ff1, ff2, count, and hold counter;
- button_db, press_pulse, release_pulse, and long_pulse.
REQ-017 Reset asserted mid-press SHALL NOT generate release_pulse, either during reset or on exit.
REQ-018 After reset deasserts with the input held pressed, the channel SHALL follow REQ-009 from the first post-reset edge and emit press_pulse normally.

Verification (THRESHOLD=4, LONG_CYCLES=10, CHANNELS=4, ACTIVE_LOW=4'b0010)
REQ-019 The bench SHALL cover these scenarios:
- Clean press: button[0] 0->1 held -> button_db[0]=1 and press_pulse[0]=1 on edge 7; long_pulse[0]=1 exactly 10 cycles later, once.
- Bounce: button[0] toggles 1,0,1,0 each cycle, then stays 0 -> button_db[0] stays 0 and no pulses occur.
- Release: from steady pressed (count=4), button[0]->0 -> button_db[0]=0 and release_pulse[0]=1 on edge 7.
- Active-low channel: button[1] held 1 after reset -> button_db[1]=0; button[1]->0 -> press_pulse[1] on edge 7.
- Simultaneous: button[2] and button[3] rise on the same edge -> press_pulse[3:2]=2'b11 in the same cycle.
- Mid-press reset: reset asserted 1 cycle while button_db[0]=1 -> all outputs 0 the next cycle, no release_pulse; press_pulse[0] reappears 7 edges after reset deasserts with the input still held.
